// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point helpers: signed saturation limits, binary-point shift
// derivation, and the rounding / saturation mode encodings.
package nn_fixed_pkg;

  typedef enum logic {
    RND_FLOOR   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  typedef enum logic {
    SAT_WRAP = 1'b0,
    SAT_CLIP = 1'b1
  } sat_mode_e;

  // Right-shift that moves a value from din_point to dout_point fractional bits.
  function automatic int shift_of(input int din_point, input int dout_point);
    return din_point - dout_point;
  endfunction

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One requantiser channel: stage 1 sign-extends and adds the rounding bias,
// stage 2 shifts, detects overflow and clips or wraps. Widths up to 62 bits.
module requant_lane
  import nn_fixed_pkg::*;
#(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 16,
  parameter int SHIFT      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s1_en_i,
  input  logic                  s2_en_i,
  input  logic [DIN_WIDTH-1:0]  din_i,
  input  logic                  round_en_i,
  input  logic                  sat_en_i,
  output logic [DOUT_WIDTH-1:0] dout_o,
  output logic                  ovf_o
);

  localparam int SW = DIN_WIDTH + 1;
  localparam logic signed [SW-1:0] HALF  = SW'((64'd1 << SHIFT) >> 1);
  localparam logic signed [63:0]   MAX_V = sat_max(DOUT_WIDTH);
  localparam logic signed [63:0]   MIN_V = sat_min(DOUT_WIDTH);

  logic signed [SW-1:0]  sum_d, sum_q;
  sat_mode_e             sat_q;
  logic signed [SW-1:0]  shifted;
  logic signed [63:0]    shifted_ext;
  logic [DOUT_WIDTH-1:0] dout_d, dout_q;
  logic                  ovf_d, ovf_q;

  // The extra bit keeps max-positive plus the rounding bias from wrapping.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sum_d = {din_i[DIN_WIDTH-1], din_i};
    if (round_mode_e'(round_en_i) == RND_HALF_UP) sum_d = sum_d + HALF;
  end

  // NOTE: datapath registers are a handful of flops, not a memory, so they reset with everything else.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      sat_q <= SAT_WRAP;
    end else if (s1_en_i) begin
      sum_q <= sum_d;
      sat_q <= sat_mode_e'(sat_en_i);
    end
  end

  always_comb begin
    shifted     = sum_q >>> SHIFT;
    shifted_ext = {{(64 - SW){shifted[SW-1]}}, shifted};
    ovf_d       = (shifted_ext > MAX_V) || (shifted_ext < MIN_V);
    dout_d      = shifted_ext[DOUT_WIDTH-1:0];
    if (ovf_d && sat_q == SAT_CLIP)
      dout_d = shifted_ext[63] ? MIN_V[DOUT_WIDTH-1:0] : MAX_V[DOUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (s2_en_i) begin
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout_o = dout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/requantize.sv
// Multi-channel requantiser top: two-stage valid/ready pipeline, sticky
// per-channel overflow flags, optional overflow counter (REQUANT_OVF_COUNT_EN).
module requantize
  import nn_fixed_pkg::*;
#(
  parameter int PARALLEL_IN = 4,
  parameter int DIN_WIDTH   = 32,
  parameter int DIN_POINT   = 16,
  parameter int DOUT_WIDTH  = 16,
  parameter int DOUT_POINT  = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PARALLEL_IN*DIN_WIDTH-1:0]  din,
  input  logic                              din_valid,
  output logic                              din_ready,
  input  logic                              round_en,
  input  logic                              sat_en,
  output logic [PARALLEL_IN*DOUT_WIDTH-1:0] dout,
  output logic                              dout_valid,
  input  logic                              dout_ready,
  output logic [PARALLEL_IN-1:0]            ovf_flag,
  input  logic                              ovf_clear,
  output logic [CNT_WIDTH-1:0]              ovf_count
);

  localparam int SHIFT = shift_of(DIN_POINT, DOUT_POINT);

  logic                   s1_valid_d, s1_valid_q;
  logic                   s2_valid_d, s2_valid_q;
  logic                   s1_en, s2_en, s1_load, s2_load, xfer;
  logic [PARALLEL_IN-1:0] lane_ovf;
  logic [PARALLEL_IN-1:0] ovf_flag_d, ovf_flag_q;

  // A stage advances when empty or when the stage after it advances.
  assign s2_en     = !s2_valid_q || dout_ready;
  assign s1_en     = !s1_valid_q || s2_en;
  assign din_ready = s1_en;
  assign s1_load   = s1_en && din_valid;
  assign s2_load   = s2_en && s1_valid_q;
  assign xfer      = s2_valid_q && dout_ready;

  always_comb begin
    s1_valid_d = s1_en ? din_valid  : s1_valid_q;
    s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
    ovf_flag_d = (ovf_clear ? '0 : ovf_flag_q) | (xfer ? lane_ovf : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      ovf_flag_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

  for (genvar i = 0; i < PARALLEL_IN; i++) begin : g_lane
    requant_lane #(
      .DIN_WIDTH  (DIN_WIDTH),
      .DOUT_WIDTH (DOUT_WIDTH),
      .SHIFT      (SHIFT)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .s1_en_i    (s1_load),
      .s2_en_i    (s2_load),
      .din_i      (din[i*DIN_WIDTH +: DIN_WIDTH]),
      .round_en_i (round_en),
      .sat_en_i   (sat_en),
      .dout_o     (dout[i*DOUT_WIDTH +: DOUT_WIDTH]),
      .ovf_o      (lane_ovf[i])
    );
  end

  assign dout_valid = s2_valid_q;
  assign ovf_flag   = ovf_flag_q;

`ifdef REQUANT_OVF_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

  // Clear first, then increment: a clear coinciding with an overflowing beat leaves 1.
  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clear) cnt_d = '0;
    if (xfer && |lane_ovf && cnt_d != '1) cnt_d = cnt_d + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ovf_count = cnt_q;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_requantize.sv
// Directed bench for requantize (SHIFT=8, CNT_WIDTH=2): vector table plus
// sequences for sticky flags, counter, backpressure and mid-stream reset.
module tb_requantize;

  localparam int CW = 2;
`ifdef REQUANT_OVF_COUNT_EN
  localparam logic [CW-1:0] EXP_CNT_SAT = 2'd3;
  localparam logic [CW-1:0] EXP_CNT_ONE = 2'd1;
`else
  localparam logic [CW-1:0] EXP_CNT_SAT = 2'd0;
  localparam logic [CW-1:0] EXP_CNT_ONE = 2'd0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [127:0]  din;
  logic          din_valid, din_ready, round_en, sat_en;
  logic [63:0]   dout;
  logic          dout_valid, dout_ready;
  logic [3:0]    ovf_flag;
  logic          ovf_clear;
  logic [CW-1:0] ovf_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  requantize #(
    .PARALLEL_IN (4),
    .DIN_WIDTH   (32),
    .DIN_POINT   (16),
    .DOUT_WIDTH  (16),
    .DOUT_POINT  (8),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .round_en   (round_en),
    .sat_en     (sat_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .ovf_flag   (ovf_flag),
    .ovf_clear  (ovf_clear),
    .ovf_count  (ovf_count)
  );

  typedef struct {
    logic [127:0] din;
    logic         rnd;
    logic         sat;
    logic [63:0]  exp_dout;
    logic [3:0]   exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drives one beat from a post-edge point, waits (bounded) for it to emerge,
  // optionally pulses ovf_clear on the transfer edge; returns just after that edge.
  task automatic run_beat(input logic [127:0] d, input logic r, input logic s, input bit clr,
                          output logic [63:0] got, output int lat);
    din = d; round_en = r; sat_en = s; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    din = {$urandom, $urandom, $urandom, $urandom};
    round_en = ~r; sat_en = ~s;
    lat = 1;
    @(negedge clk);
    while (!dout_valid && lat < 6) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    got = dout;
    if (clr) ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
  endtask

  task automatic pulse_clear();
    ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0]  got;
    int           lat;
    logic [127:0] d_ovf;
    int           rx;
    bit           mon_done;
    bit           seen;

    vecs[0] = '{{32'h0, 32'h0, 32'h0, 32'h00000180}, 1'b0, 1'b1,
                {16'h0000, 16'h0000, 16'h0000, 16'h0001}, 4'b0000};
    vecs[1] = '{{32'h80000000, 32'h01000000, 32'hFFFFFE80, 32'h00000180}, 1'b1, 1'b1,
                {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0002}, 4'b1100};
    vecs[2] = '{{32'h80000000, 32'h01000000, 32'hFFFFFE80, 32'h00000180}, 1'b0, 1'b0,
                {16'h0000, 16'h0000, 16'hFFFE, 16'h0001}, 4'b1100};
    vecs[3] = '{{32'hFF7FFFFF, 32'hFF800000, 32'h00800000, 32'h007FFF00}, 1'b0, 1'b1,
                {16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF}, 4'b1010};
    vecs[4] = '{{32'hFFFFFF7F, 32'hFFFFFF80, 32'h007FFF7F, 32'h7FFFFFFF}, 1'b1, 1'b1,
                {16'hFFFF, 16'h0000, 16'h7FFF, 16'h7FFF}, 4'b0001};
    vecs[5] = '{{32'h0, 32'hFFFF1234, 32'h00001234, 32'h12345678}, 1'b0, 1'b0,
                {16'h0000, 16'hFF12, 16'h0012, 16'h3456}, 4'b0001};

    rst_n = 1'b0; din = '0; din_valid = 1'b0; round_en = 1'b0; sat_en = 1'b0;
    dout_ready = 1'b1; ovf_clear = 1'b0;

    #12;
    check("reset_din_ready", 64'(din_ready), 64'd1);
    check("reset_dout_valid", 64'(dout_valid), 64'd0);
    check("reset_dout", dout, 64'd0);
    check("reset_ovf_flag", 64'(ovf_flag), 64'd0);
    check("reset_ovf_count", 64'(ovf_count), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_beat(vecs[i].din, vecs[i].rnd, vecs[i].sat, 1'b0, got, lat);
      check($sformatf("vec%0d_dout", i), got, vecs[i].exp_dout);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      @(negedge clk);
      check($sformatf("vec%0d_ovf_flag", i), 64'(ovf_flag), 64'(vecs[i].exp_ovf));
      pulse_clear();
    end

    // Sticky flags, then clear coinciding with a new overflow: set wins.
    @(negedge clk);
    check("flag_after_clear", 64'(ovf_flag), 64'd0);
    @(posedge clk); #1;
    run_beat(vecs[4].din, 1'b1, 1'b1, 1'b0, got, lat);
    run_beat(vecs[0].din, 1'b0, 1'b1, 1'b0, got, lat);
    @(negedge clk);
    check("flag_sticky", 64'(ovf_flag), 64'b0001);
    @(posedge clk); #1;
    d_ovf = {32'h0, 32'h01000000, 32'h0, 32'h0};
    run_beat(d_ovf, 1'b0, 1'b1, 1'b1, got, lat);
    check("clip_ch2_dout", got, {16'h0000, 16'h7FFF, 16'h0000, 16'h0000});
    @(negedge clk);
    check("flag_set_wins_clear", 64'(ovf_flag), 64'b0100);
    @(posedge clk); #1;

    // Overflow counter: saturates, and clear with an overflowing beat leaves 1.
    pulse_clear();
    for (int i = 0; i < 5; i++) run_beat(vecs[1].din, 1'b1, 1'b1, 1'b0, got, lat);
    @(negedge clk);
    check("count_saturate", 64'(ovf_count), 64'(EXP_CNT_SAT));
    @(posedge clk); #1;
    run_beat(vecs[1].din, 1'b1, 1'b1, 1'b1, got, lat);
    @(negedge clk);
    check("count_clear_and_inc", 64'(ovf_count), 64'(EXP_CNT_ONE));
    @(posedge clk); #1;

    // Backpressure: 10 beats against a dout_ready toggling every cycle.
    rx = 0; mon_done = 1'b0;
    fork
      begin : drv
        for (int k = 0; k < 10; k++) begin
          logic rdy;
          int   guard;
          din = {32'h0, 32'h0, 32'(k + 100) << 8, 32'(k) << 8};
          round_en = 1'b0; sat_en = 1'b1; din_valid = 1'b1;
          guard = 0;
          do begin
            @(negedge clk); rdy = din_ready;
            @(posedge clk); #1;
            guard++;
          end while (!rdy && guard < 20);
        end
        din_valid = 1'b0;
      end
      begin : mon
        bit          prev_stall;
        logic [63:0] prev_dout;
        prev_stall = 1'b0; prev_dout = '0;
        for (int c = 0; c < 100 && rx < 10; c++) begin
          @(negedge clk);
          if (prev_stall && dout_valid) check("stall_dout_stable", dout, prev_dout);
          if (dout_valid && dout_ready) begin
            check($sformatf("bp_beat%0d", rx), dout,
                  {16'h0000, 16'h0000, 16'(rx + 100), 16'(rx)});
            rx++;
          end
          prev_stall = dout_valid && !dout_ready;
          prev_dout  = dout;
        end
        mon_done = 1'b1;
      end
      begin : tog
        for (int c = 0; c < 120 && !mon_done; c++) begin
          @(posedge clk); #1;
          dout_ready = ~dout_ready;
        end
      end
    join
    dout_ready = 1'b1;
    check("bp_beat_count", 64'(rx), 64'd10);
    @(negedge clk);
    check("bp_no_extra_beat", 64'(dout_valid), 64'd0);
    @(posedge clk); #1;

    // Reset with two beats in flight and flags set.
    run_beat(vecs[1].din, 1'b1, 1'b1, 1'b0, got, lat);
    dout_ready = 1'b0;
    din = vecs[1].din; round_en = 1'b1; sat_en = 1'b1; din_valid = 1'b1;
    @(posedge clk); #1;
    din = vecs[3].din;
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_dout_valid", 64'(dout_valid), 64'd1);
    check("pre_reset_flag", 64'(ovf_flag), 64'b1100);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_dout_valid", 64'(dout_valid), 64'd0);
    check("async_reset_ovf_flag", 64'(ovf_flag), 64'd0);
    check("async_reset_dout", dout, 64'd0);
    check("async_reset_din_ready", 64'(din_ready), 64'd1);
    @(posedge clk); #3 rst_n = 1'b1;
    dout_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (dout_valid) seen = 1'b1;
    end
    check("no_stale_beats", 64'(seen), 64'd0);
    check("post_reset_count", 64'(ovf_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
